// File: rtl/apb_requester.sv
// Single-outstanding APB4 requester: request handshake -> SETUP -> ACCESS -> response handshake.
// Minimum latency is 3 cycles from request handshake to rsp_valid; req_ready is low until the response is taken.
module apb_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic        PREADY,
  input  logic [31:0] PRDATA,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [15:0] L_TMO    = 16'(TIMEOUT_CYCLES);
  localparam logic        L_TMO_EN = (TIMEOUT_CYCLES != 0);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic        r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_strb;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [15:0] r_wait_cnt;
  logic        w_handshake;
  logic        w_done;
  logic        w_timeout;

  // Gating with PRESETn keeps req_ready low for the whole reset and high on the first cycle after it.
  assign req_ready   = PRESETn && (r_state == S_IDLE);
  assign w_handshake = req_valid && req_ready;
  assign w_done      = (r_state == S_ACCESS) && PREADY;
  assign w_timeout   = L_TMO_EN && (r_state == S_ACCESS) && !PREADY && (r_wait_cnt == L_TMO);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_handshake) w_next = S_SETUP;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout) w_next = S_RESP;
      S_RESP:   if (rsp_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_write    <= 1'b0;
      r_addr     <= 1'b0;
      r_wdata    <= 32'h0;
      r_strb     <= 4'h0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
      r_wait_cnt <= 16'h0;
    end else begin
      if (w_handshake) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_strb  <= req_write ? req_strb : 4'h0;
      end
      if (r_state == S_SETUP) begin
        r_wait_cnt <= 16'h0;
      end else if ((r_state == S_ACCESS) && !PREADY && (r_wait_cnt != 16'hFFFF)) begin
        r_wait_cnt <= r_wait_cnt + 16'h1;
      end
      // A completing PREADY wins over a timeout landing in the same cycle.
      if (w_done) begin
        r_rdata <= r_write ? 32'h0 : PRDATA;
        r_err   <= PSLVERR;
      end else if (w_timeout) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end
    end
  end

  assign PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE   = (r_state == S_ACCESS);
  assign PADDR     = r_addr;
  assign PWRITE    = r_write;
  assign PWDATA    = r_wdata;
  assign PSTRB     = r_strb;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
